prbs15_byte_errgen: RTL and testbench

- Transmit-side PRBS15 byte source with controlled bit-error injection.
- Companion to prbs15_byteber: it drives the checker's data_in with a known, countable number of corrupted bits, so a measured bit_errors value can be compared against ground truth.
- Sits in the loopback transmit path ahead of the serializer. It replaces ad-hoc OR-masking of the generator output.

---
 rtl/prbs15_byte_errgen.sv | 146 ++++++++++++++
 tb/tb_prbs15_byte_errgen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs15_byte_errgen.sv
// PRBS15 (x^15+x^14+1) byte source, MSB first, with XOR bit-error injection (single-shot or periodic).
// Optional output inversion when PRBS_ERRGEN_INVERT_EN is defined.
module prbs15_byte_errgen #(
  parameter logic [14:0] SEED     = 15'h7FFF,
  parameter int          PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [1:0]          inj_mode,
  input  logic                inj_once,
  input  logic [7:0]          inj_mask,
  input  logic [PERIOD_W-1:0] inj_period,
  input  logic                clear_count,
`ifdef PRBS_ERRGEN_INVERT_EN
  input  logic                invert,
`endif
  output logic [7:0]          data_out,
  output logic                data_valid,
  output logic                inj_flag,
  output logic [31:0]         inj_count,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_SINGLE   = 2'd1,
    ST_PERIODIC = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [14:0]         lfsr, lfsr_next;
  logic [7:0]          prbs_byte;
  logic                pending, pending_next;
  logic [PERIOD_W-1:0] period_cnt, period_cnt_next;
  logic                inject;
  logic [3:0]          mask_ones;
  logic [31:0]         count_base, count_next;
  logic [32:0]         count_sum;
  logic [7:0]          out_byte;

  // Eight LFSR steps per byte; the first generated bit lands in bit 7.
  always_comb begin : lfsr_step
    logic nb;
    nb        = 1'b0;
    lfsr_next = lfsr;
    prbs_byte = '0;
    for (int i = 0; i < 8; i++) begin
      nb           = lfsr_next[14] ^ lfsr_next[13];
      lfsr_next    = {lfsr_next[13:0], nb};
      prbs_byte[7-i] = nb;
    end
  end

  always_comb begin
    mask_ones = '0;
    for (int i = 0; i < 8; i++) begin
      mask_ones = mask_ones + {3'b000, inj_mask[i]};
    end
  end

  // Injection decisions use the registered state; a mode change only takes
  // effect at the next edge and wipes pending and the period counter.
  always_comb begin
    case (inj_mode)
      2'b01:   state_next = ST_SINGLE;
      2'b10:   state_next = ST_PERIODIC;
      default: state_next = ST_OFF;
    endcase
    inject          = 1'b0;
    pending_next    = pending;
    period_cnt_next = period_cnt;
    case (state)
      ST_SINGLE: begin
        inject = enable && (pending || inj_once);
        if (inject) begin
          pending_next = 1'b0;
        end else if (inj_once) begin
          pending_next = 1'b1;
        end
      end
      ST_PERIODIC: begin
        if (enable) begin
          if (inj_period == '0) begin
            period_cnt_next = '0;
          end else if (period_cnt == inj_period - PERIOD_W'(1)) begin
            inject          = 1'b1;
            period_cnt_next = '0;
          end else begin
            period_cnt_next = period_cnt + PERIOD_W'(1);
          end
        end
      end
      default: ;
    endcase
    if (state_next != state) begin
      pending_next    = 1'b0;
      period_cnt_next = '0;
    end
  end

  // Clear is applied before the add, so a coinciding injection still counts.
  always_comb begin
    count_base = clear_count ? 32'd0 : inj_count;
    count_sum  = {1'b0, count_base} + {29'd0, mask_ones};
    count_next = count_base;
    if (inject) begin
      count_next = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    end
  end

  always_comb begin
    out_byte = prbs_byte ^ (inject ? inj_mask : 8'h00);
`ifdef PRBS_ERRGEN_INVERT_EN
    out_byte = out_byte ^ {8{invert}};
`endif
  end

  // enable acts as a one-way valid: no backpressure, one byte per enabled clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_OFF;
      lfsr       <= SEED;
      pending    <= 1'b0;
      period_cnt <= '0;
      inj_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      inj_flag   <= 1'b0;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      period_cnt <= period_cnt_next;
      inj_count  <= count_next;
      data_valid <= enable;
      inj_flag   <= inject;
      if (enable) begin
        lfsr     <= lfsr_next;
        data_out <= out_byte;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_prbs15_byte_errgen.sv
// Directed + randomized bench for prbs15_byte_errgen against a bit-stream reference model.
module tb_prbs15_byte_errgen;
  localparam int          PW   = 16;
  localparam logic [14:0] SEED = 15'h7FFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    inj_mode = 2'b00;
  logic          inj_once = 1'b0;
  logic [7:0]    inj_mask = 8'h00;
  logic [PW-1:0] inj_period = '0;
  logic          clear_count = 1'b0;
`ifdef PRBS_ERRGEN_INVERT_EN
  logic          invert = 1'b0;
`endif
  logic [7:0]    data_out;
  logic          data_valid;
  logic          inj_flag;
  logic [31:0]   inj_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs15_byte_errgen #(.SEED(SEED), .PERIOD_W(PW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .inj_mode(inj_mode),
    .inj_once(inj_once),
    .inj_mask(inj_mask),
    .inj_period(inj_period),
    .clear_count(clear_count),
`ifdef PRBS_ERRGEN_INVERT_EN
    .invert(invert),
`endif
    .data_out(data_out),
    .data_valid(data_valid),
    .inj_flag(inj_flag),
    .inj_count(inj_count),
    .state_dbg(state_dbg)
  );

  // Reference model: PRBS as a bit stream where bit[n] = bit[n-15] ^ bit[n-14].
  bit         hist[$];
  int         m_mode;      // 0 off, 1 single, 2 periodic
  bit         m_pending;
  int         m_idx;       // enabled bytes since entering periodic mode
  longint     m_count;
  logic [7:0] m_data;
  logic [7:0] m_clean;
  bit         m_valid;
  bit         m_flag;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 15; i++) hist.push_back(SEED[14-i]);
    m_mode = 0; m_pending = 0; m_idx = 0; m_count = 0;
    m_data = 8'h00; m_clean = 8'h00; m_valid = 0; m_flag = 0;
  endtask

  function automatic logic [7:0] next_prbs_byte();
    logic [7:0] b;
    bit nb;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nb = hist[0] ^ hist[1];
      hist.push_back(nb);
      void'(hist.pop_front());
      b = {b[6:0], nb};
    end
    return b;
  endfunction

  task automatic model_edge();
    int tgt;
    bit inj;
    logic [7:0] b;
    tgt = (inj_mode == 2'b01) ? 1 : (inj_mode == 2'b10) ? 2 : 0;
    inj = 0;
    if (enable) begin
      b = next_prbs_byte();
      if (m_mode == 1) inj = m_pending || inj_once;
      if (m_mode == 2 && inj_period != 0) inj = ((m_idx + 1) % int'(inj_period)) == 0;
      m_clean = b;
      m_data  = inj ? (b ^ inj_mask) : b;
`ifdef PRBS_ERRGEN_INVERT_EN
      m_data  = m_data ^ {8{invert}};
`endif
    end
    m_valid = enable;
    m_flag  = inj;
    if (clear_count) m_count = 0;
    if (inj) begin
      m_count = m_count + $countones(inj_mask);
      if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;
    end
    if (tgt != m_mode) begin
      m_pending = 0;
      m_idx = 0;
    end else begin
      if (m_mode == 1) begin
        if (inj) m_pending = 0;
        else if (inj_once) m_pending = 1;
      end
      if (m_mode == 2 && enable) m_idx = (inj_period == 0) ? 0 : m_idx + 1;
    end
    m_mode = tgt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out", {24'd0, data_out}, {24'd0, m_data});
    chk("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
    chk("inj_flag", {31'd0, inj_flag}, {31'd0, m_flag});
    chk("inj_count", inj_count, m_count[31:0]);
  endtask

  // Inputs change only at negedge; model advances on the posedge, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic reset_phase(input int n);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (n) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int pulses, last, base;
    logic [7:0] inv;

    // Reset state and first bytes
    #1;
    reset_phase(3);
    enable = 1'b1;
    tick(); chk("first_byte", {24'd0, data_out}, 32'h00);
    tick(); chk("second_byte", {24'd0, data_out}, 32'h02);
    repeat (20) tick();

    // Periodic, period 16, mask 04
    enable = 1'b0; inj_mode = 2'b10; inj_period = 16; inj_mask = 8'h04;
    tick();
    enable = 1'b1;
    pulses = 0; last = -1;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (inj_flag) begin
        if (last >= 0) chk("flag_gap", i - last, 16);
        last = i;
        pulses++;
      end
    end
    chk("period_pulses", pulses, 100);
    chk("period_count", inj_count, 100);

    // Single-shot: two requests while idle give one injection
    enable = 1'b0; inj_mode = 2'b01;
    tick();
    clear_count = 1'b1; tick(); clear_count = 1'b0;
    inj_once = 1'b1; tick(); inj_once = 1'b0; tick();
    inj_once = 1'b1; tick(); inj_once = 1'b0;
    enable = 1'b1; pulses = 0;
    repeat (4) begin
      tick();
      if (inj_flag) pulses++;
    end
    chk("single_pulses", pulses, 1);
    chk("single_count", inj_count, 1);

    // Period 1, mask FF: every byte is the complement of clean PRBS
    enable = 1'b0; inj_mode = 2'b10; inj_period = 1; inj_mask = 8'hFF;
    tick();
    enable = 1'b1;
    base = int'(inj_count);
    repeat (10) begin
      tick();
      inv = ~m_clean;
      chk("inverted_byte", {24'd0, data_out}, {24'd0, inv});
    end
    chk("period1_count", inj_count, base + 80);

    // Saturation, then clear coinciding with an injection
    force dut.inj_count = 32'hFFFF_FFF8;
    m_count = 64'hFFFF_FFF8;
    #1;
    release dut.inj_count;
    tick(); chk("sat_first", inj_count, 32'hFFFF_FFFF);
    tick(); chk("sat_second", inj_count, 32'hFFFF_FFFF);
    clear_count = 1'b1; inj_mask = 8'h03;
    tick(); chk("clear_then_add", inj_count, 2);
    clear_count = 1'b0;

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom_range(0, 3) != 0);
      inj_once    = ($urandom_range(0, 5) == 0);
      inj_mask    = 8'($urandom);
      clear_count = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) inj_mode = 2'($urandom_range(0, 3));
      if (m_mode != 2 && inj_mode != 2'b10) inj_period = PW'($urandom_range(0, 5));
      tick();
    end
    inj_once = 1'b0; clear_count = 1'b0;

    // Mid-run reset with a pending request outstanding
    enable = 1'b0; inj_mode = 2'b01; inj_mask = 8'h10;
    tick();
    inj_once = 1'b1; tick(); inj_once = 1'b0;
    reset_phase(3);
    enable = 1'b1;
    tick(); chk("restart_byte0", {24'd0, data_out}, 32'h00);
    tick(); chk("restart_byte1", {24'd0, data_out}, 32'h02);
    chk("restart_no_flag", {31'd0, inj_flag}, 32'd0);
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
